// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending purchase controller.
package vend_pkg;
   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_VEND, S_CHANGE} state_t;
   localparam logic [3:0] COIN_1  = 4'd1;
   localparam logic [3:0] COIN_2  = 4'd2;
   localparam logic [3:0] COIN_5  = 4'd5;
   localparam logic [3:0] COIN_10 = 4'd10;
   localparam logic [1:0] ERR_OVF   = 2'b01;
   localparam logic [1:0] ERR_EMPTY = 2'b10;
   localparam logic [1:0] ERR_FUNDS = 2'b11;
   localparam int STOCK_W = 5;
   localparam int N_ITEMS = 4;
   function automatic logic [3:0] coin_value(input logic [1:0] t);
      return t == 2'b00 ? COIN_1 : t == 2'b01 ? COIN_2 : t == 2'b10 ? COIN_5 : COIN_10;
   endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: purchase-side bus of the vending controller; master drives coins/selections/stock.
interface vend_if
   import vend_pkg::*;
#(parameter int CREDIT_W = 8);
   logic                       coin_valid;
   logic [1:0]                 coin_type;
   logic                       sel_valid;
   logic [1:0]                 sel_item;
   logic                       cancel;
   logic [N_ITEMS*STOCK_W-1:0] stock;
   logic [CREDIT_W-1:0]        credit;
   logic                       busy;
   logic                       vend_valid;
   logic [1:0]                 vend_item;
   logic                       change_valid;
   logic [CREDIT_W-1:0]        change_amt;
   logic                       err;
   logic [1:0]                 err_code;
   modport master (output coin_valid, coin_type, sel_valid, sel_item, cancel, stock,
                   input credit, busy, vend_valid, vend_item, change_valid, change_amt, err, err_code);
   modport slave  (input coin_valid, coin_type, sel_valid, sel_item, cancel, stock,
                   output credit, busy, vend_valid, vend_item, change_valid, change_amt, err, err_code);
endinterface

// File: rtl/vend_coin_acc.sv
// vend_coin_acc: coin decode, ceiling check and credit register (clear > subtract > load).
module vend_coin_acc
   import vend_pkg::*;
#(parameter int CREDIT_W = 8, parameter int MAX_CREDIT = 200)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [1:0]          coin_type,
   input  logic                sub,
   input  logic [CREDIT_W-1:0] sub_amt,
   input  logic                clr,
   output logic [CREDIT_W-1:0] credit,
   output logic                ovf
);
   logic [CREDIT_W:0] sum;
   assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_type));
   assign ovf = sum > (CREDIT_W+1)'(MAX_CREDIT);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) credit <= '0;
      else if (clr) credit <= '0;
      else if (sub) credit <= credit - sub_amt;
      else if (load && !ovf) credit <= sum[CREDIT_W-1:0];
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending purchase FSM - credit, price/stock check, registered vend/change/err pulses.
// VEND_AUTO_CANCEL_EN: refund full credit after TIMEOUT_CYC idle cycles in COLLECT.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int CREDIT_W    = 8,
   parameter int MAX_CREDIT  = 200,
   parameter int PRICE0      = 15,
   parameter int PRICE1      = 20,
   parameter int PRICE2      = 25,
   parameter int PRICE3      = 40,
   parameter int TIMEOUT_CYC = 1000
)
(
   input logic   clk,
   input logic   rst_n,
   vend_if.slave bus
);
   state_t               state, nxt;
   logic [1:0]           item;
   logic [CREDIT_W-1:0]  credit, price, change_amt_d;
   logic [STOCK_W-1:0]   item_stock;
   logic                 ovf, timeout, open, do_cancel, do_sel, do_coin, ok;
   logic                 vend_valid_d, change_valid_d;
   logic [1:0]           vend_item_d, err_code_d;

   vend_coin_acc #(.CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT)) u_acc (
      .clk(clk), .rst_n(rst_n), .load(do_coin), .coin_type(bus.coin_type),
      .sub(state == S_VEND), .sub_amt(price), .clr(state == S_CHANGE),
      .credit(credit), .ovf(ovf)
   );

   assign price = item == 2'd0 ? CREDIT_W'(PRICE0) : item == 2'd1 ? CREDIT_W'(PRICE1) :
                  item == 2'd2 ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
   assign item_stock = bus.stock[item*STOCK_W +: STOCK_W];
   assign ok         = item_stock != '0 && credit >= price;
   assign open       = state == S_IDLE || state == S_COLLECT;
   // cancel outranks everything even in IDLE, where it simply does nothing
   assign do_cancel  = state == S_COLLECT && (bus.cancel || timeout);
   assign do_sel     = open && !bus.cancel && !timeout && bus.sel_valid;
   assign do_coin    = open && !bus.cancel && !timeout && !bus.sel_valid && bus.coin_valid;
   assign bus.credit = credit;
   assign bus.busy   = !open;

`ifdef VEND_AUTO_CANCEL_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) to_cnt <= '0;
      else to_cnt <= (state != S_COLLECT || do_sel || (do_coin && !ovf)) ? '0 : to_cnt + 1'b1;
   assign timeout = state == S_COLLECT && to_cnt == TW'(TIMEOUT_CYC - 1);
`else
   assign timeout = TIMEOUT_CYC < 0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state            <= S_IDLE;
         item             <= '0;
         bus.vend_valid   <= 1'b0;
         bus.vend_item    <= '0;
         bus.change_valid <= 1'b0;
         bus.change_amt   <= '0;
         bus.err          <= 1'b0;
         bus.err_code     <= '0;
      end else begin
         state            <= nxt;
         item             <= do_sel ? bus.sel_item : item;
         bus.vend_valid   <= vend_valid_d;
         bus.vend_item    <= vend_item_d;
         bus.change_valid <= change_valid_d;
         bus.change_amt   <= change_amt_d;
         bus.err          <= err_code_d != 2'b00;
         bus.err_code     <= err_code_d;
      end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE, S_COLLECT: nxt = do_cancel ? S_CHANGE : do_sel ? S_CHECK :
                                  (do_coin && !ovf) ? S_COLLECT : state;
         S_CHECK:           nxt = ok ? S_VEND : credit != '0 ? S_COLLECT : S_IDLE;
         S_VEND:            nxt = S_CHANGE;
         S_CHANGE:          nxt = S_IDLE;
         default:           nxt = S_IDLE;
      endcase
   end

   always_comb begin
      vend_valid_d   = state == S_CHECK && ok;
      vend_item_d    = vend_valid_d ? item : 2'b00;
      change_valid_d = (do_cancel && credit != '0) || (state == S_VEND && credit != price);
      change_amt_d   = !change_valid_d ? '0 : do_cancel ? credit : credit - price;
      err_code_d     = (do_coin && ovf) ? ERR_OVF :
                       (state == S_CHECK && item_stock == '0) ? ERR_EMPTY :
                       (state == S_CHECK && credit < price) ? ERR_FUNDS : 2'b00;
   end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed vectors for vend_ctrl with hand-computed expectations.
// With VEND_AUTO_CANCEL_EN the auto-refund after 8 idle cycles is also exercised.
module tb_vend_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   vend_if #(.CREDIT_W(8)) bus();
   vend_ctrl #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // drive one cycle of strobes starting at a falling edge; returns at the next falling edge
   task automatic strobe(input logic c, input logic [1:0] ct, input logic s,
                         input logic [1:0] si, input logic k);
      bus.coin_valid = c;
      bus.coin_type  = ct;
      bus.sel_valid  = s;
      bus.sel_item   = si;
      bus.cancel     = k;
      @(negedge clk);
      bus.coin_valid = 1'b0;
      bus.sel_valid  = 1'b0;
      bus.cancel     = 1'b0;
   endtask

   task automatic coin(input logic [1:0] t);
      strobe(1'b1, t, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic sel(input logic [1:0] i);
      strobe(1'b0, 2'd0, 1'b1, i, 1'b0);
   endtask

   task automatic cancel_req();
      strobe(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
   endtask

   initial begin
      bus.coin_valid = 1'b0;
      bus.coin_type  = 2'd0;
      bus.sel_valid  = 1'b0;
      bus.sel_item   = 2'd0;
      bus.cancel     = 1'b0;
      bus.stock      = {5'd3, 5'd0, 5'd3, 5'd3};
      repeat (2) @(negedge clk);
      chk("rst_credit", bus.credit, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_vend", bus.vend_valid, 0);
      chk("rst_change", bus.change_valid, 0);
      chk("rst_err", bus.err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // exact payment: 10 + 5 for item 0 at 15
      coin(2'd3);
      chk("t1_credit10", bus.credit, 10);
      coin(2'd2);
      chk("t1_credit15", bus.credit, 15);
      sel(2'd0);
      chk("t1_check_busy", bus.busy, 1);
      chk("t1_check_novend", bus.vend_valid, 0);
      @(negedge clk);
      chk("t1_vend", bus.vend_valid, 1);
      chk("t1_vend_item", bus.vend_item, 0);
      chk("t1_noerr", bus.err, 0);
      @(negedge clk);
      chk("t1_nochange", bus.change_valid, 0);
      chk("t1_credit0", bus.credit, 0);
      chk("t1_vend_once", bus.vend_valid, 0);
      @(negedge clk);
      chk("t1_idle", bus.busy, 0);

      // overpayment: 30 for item 1 at 20 -> change 10
      repeat (3) coin(2'd3);
      chk("t2_credit30", bus.credit, 30);
      sel(2'd1);
      @(negedge clk);
      chk("t2_vend", bus.vend_valid, 1);
      chk("t2_vend_item", bus.vend_item, 1);
      @(negedge clk);
      chk("t2_change", bus.change_valid, 1);
      chk("t2_change_amt", bus.change_amt, 10);
      @(negedge clk);
      chk("t2_change_once", bus.change_valid, 0);
      chk("t2_idle", bus.busy, 0);
      chk("t2_credit0", bus.credit, 0);

      // insufficient funds, then cancel refunds from COLLECT
      coin(2'd3);
      sel(2'd3);
      @(negedge clk);
      chk("t3_err", bus.err, 1);
      chk("t3_err_code", bus.err_code, 3);
      chk("t3_novend", bus.vend_valid, 0);
      @(negedge clk);
      chk("t3_err_once", bus.err, 0);
      chk("t3_credit", bus.credit, 10);
      chk("t3_notbusy", bus.busy, 0);
      cancel_req();
      chk("t3_refund", bus.change_valid, 1);
      chk("t3_refund_amt", bus.change_amt, 10);
      @(negedge clk);
      chk("t3_credit0", bus.credit, 0);

      // empty item 2 with enough credit
      repeat (4) coin(2'd3);
      sel(2'd2);
      @(negedge clk);
      chk("t4_err", bus.err, 1);
      chk("t4_err_code", bus.err_code, 2);
      chk("t4_novend", bus.vend_valid, 0);
      @(negedge clk);
      chk("t4_credit", bus.credit, 40);
      cancel_req();
      chk("t4_refund_amt", bus.change_amt, 40);
      @(negedge clk);

      // ceiling: 195 + 10 rejected, then cancel outranks coin and sel
      repeat (19) coin(2'd3);
      coin(2'd2);
      chk("t5_credit195", bus.credit, 195);
      coin(2'd3);
      chk("t5_ovf", bus.err, 1);
      chk("t5_ovf_code", bus.err_code, 1);
      chk("t5_credit_kept", bus.credit, 195);
      @(negedge clk);
      chk("t5_ovf_once", bus.err, 0);
      strobe(1'b1, 2'd0, 1'b1, 2'd0, 1'b1);
      chk("t5_refund", bus.change_valid, 1);
      chk("t5_refund_amt", bus.change_amt, 195);
      chk("t5_no_err", bus.err, 0);
      @(negedge clk);
      chk("t5_credit0", bus.credit, 0);
      chk("t5_idle", bus.busy, 0);
      @(negedge clk);
      chk("t5_no_vend", bus.vend_valid, 0);

      // asynchronous reset during VEND
      coin(2'd3);
      coin(2'd2);
      sel(2'd0);
      @(negedge clk);
      chk("t6_vend", bus.vend_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vend", bus.vend_valid, 0);
      chk("t6_rst_credit", bus.credit, 0);
      chk("t6_rst_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_no_change", bus.change_valid, 0);
      chk("t6_idle", bus.busy, 0);
      chk("t6_credit0", bus.credit, 0);

`ifdef VEND_AUTO_CANCEL_EN
      begin
         int seen = 0;
         logic [7:0] amt = '0;
         coin(2'd2);
         for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.change_valid) begin
               seen = k;
               amt  = bus.change_amt;
            end
         end
         chk("t7_timeout_cycle", seen, 8);
         chk("t7_timeout_amt", amt, 5);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
